// File: rtl/fetch_controller.sv
// Instruction fetch front end: loads a program into instruction memory byte by byte,
// then drives the PC into the memory read port and registers fetched words into IF/ID.
module fetch_controller #(
  parameter int PC_WIDTH          = 32,
  parameter int MEMORY_SIZE       = 1024,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_load,
  input  logic                         start_run,
  input  logic [7:0]                   load_byte,
  input  logic                         load_valid,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic                         imem_we,
  output logic [PC_WIDTH-1:0]          imem_waddr,
  output logic [INSTRUCTION_WIDTH-1:0] imem_wdata,
  output logic [PC_WIDTH-1:0]          imem_pc,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instr,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [PC_WIDTH-1:0]          branch_target,
  input  logic                         halt_req,
  output logic [INSTRUCTION_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic                         instr_valid,
  output logic [1:0]                   state
);

  localparam int LANES  = INSTRUCTION_WIDTH / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PC_WIDTH-1:0] ADDR_MASK = PC_WIDTH'(MEMORY_SIZE - 1);
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t                       state_q;
  state_t                       state_d;
  logic [PC_WIDTH-1:0]          pc_q;
  logic [PC_WIDTH-1:0]          word_cnt;
  logic [LANE_W-1:0]            byte_idx;
  logic [INSTRUCTION_WIDTH-1:0] word_buf;
  logic                         wr_pending;
  logic                         wr_last;
  logic                         load_done;

  // The pending write is the final one when it closes the program or fills memory.
  assign load_done = wr_pending && (wr_last || (word_cnt == ADDR_MASK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALT: begin
        if (start_load) begin
          state_d = LOAD;
        end else if (start_run) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (load_done) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      wr_pending <= 1'b0;
      wr_last    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (start_load) begin
            word_cnt   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            wr_pending <= 1'b0;
            wr_last    <= 1'b0;
          end
        end
        LOAD: begin
          if (wr_pending) begin
            word_cnt   <= word_cnt + PC_WIDTH'(1);
            byte_idx   <= '0;
            word_buf   <= '0;
            wr_pending <= 1'b0;
            wr_last    <= 1'b0;
          end else if (load_valid) begin
            for (int i = 0; i < LANES; i++) begin
              if (byte_idx == LANE_W'(i)) begin
                word_buf[i*8 +: 8] <= load_byte;
              end
            end
            byte_idx <= byte_idx + LANE_W'(1);
            if ((byte_idx == LAST_LANE) || load_last) begin
              wr_pending <= 1'b1;
              wr_last    <= load_last;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Fetch priority in RUN: halt, then branch redirect (flush), then stall, then advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          instr_valid <= 1'b0;
          if (!start_load && start_run) begin
            pc_q <= '0;
          end
        end
        LOAD: begin
          instr_valid <= 1'b0;
          if (load_done) begin
            pc_q <= '0;
          end
        end
        RUN: begin
          if (halt_req) begin
            instr_valid <= 1'b0;
          end else if (branch_taken) begin
            pc_q        <= branch_target & ADDR_MASK;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            instr_out   <= imem_instr;
            pc_out      <= pc_q;
            instr_valid <= 1'b1;
            pc_q        <= (pc_q + PC_WIDTH'(1)) & ADDR_MASK;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    load_ready = (state_q == LOAD) && !wr_pending;
    imem_we    = (state_q == LOAD) && wr_pending;
    imem_waddr = word_cnt;
    imem_wdata = word_buf;
    imem_pc    = pc_q;
    state      = state_q;
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: stimulus pushes expected memory writes and
// fetched instructions from a queue/array model; a negedge monitor pops and compares.
module tb_fetch_controller;

  localparam int PW = 32;
  localparam int MS = 64;
  localparam int IW = 32;
  localparam int AW = $clog2(MS);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_load, start_run;
  logic [7:0]    load_byte;
  logic          load_valid, load_last, load_ready;
  logic          imem_we;
  logic [PW-1:0] imem_waddr;
  logic [IW-1:0] imem_wdata;
  logic [PW-1:0] imem_pc;
  logic [IW-1:0] imem_instr;
  logic          stall, branch_taken, halt_req;
  logic [PW-1:0] branch_target;
  logic [IW-1:0] instr_out;
  logic [PW-1:0] pc_out;
  logic          instr_valid;
  logic [1:0]    state;

  always #5 clk = ~clk;

  fetch_controller #(.PC_WIDTH(PW), .MEMORY_SIZE(MS), .INSTRUCTION_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_load(start_load), .start_run(start_run),
    .load_byte(load_byte), .load_valid(load_valid), .load_last(load_last),
    .load_ready(load_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .imem_pc(imem_pc), .imem_instr(imem_instr),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .state(state)
  );

  // Memory seen by the DUT, plus the bench's own idea of what it should hold.
  logic [IW-1:0] mem     [MS];
  logic [IW-1:0] ref_mem [MS];

  assign imem_instr = mem[imem_pc[AW-1:0]];

  always @(posedge clk) begin
    if (imem_we) mem[imem_waddr[AW-1:0]] <= imem_wdata;
  end

  typedef struct {
    logic [31:0]   addr;
    logic [IW-1:0] data;
  } entry_t;

  entry_t     wr_q[$];
  entry_t     fe_q[$];
  logic [7:0] lbytes[$];
  int         total  = 0;
  int         passed = 0;
  int         mpc    = 0;
  int         mwaddr = 0;
  logic          prev_valid = 1'b0;
  logic [PW-1:0] prev_pc    = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
  endtask

  task automatic failNote(input string name, input logic [31:0] actual);
    total++;
    $display("[TB] FAIL %s: actual=%h required=nothing pending", name, actual);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_state"},       32'(state), 32'd0);
    checkOutput({tag, "_load_ready"},  32'(load_ready), 32'd0);
    checkOutput({tag, "_imem_we"},     32'(imem_we), 32'd0);
    checkOutput({tag, "_imem_waddr"},  imem_waddr, 32'd0);
    checkOutput({tag, "_imem_wdata"},  imem_wdata, 32'd0);
    checkOutput({tag, "_instr_out"},   instr_out, 32'd0);
    checkOutput({tag, "_pc_out"},      pc_out, 32'd0);
    checkOutput({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    checkOutput({tag, "_imem_pc"},     imem_pc, 32'd0);
  endtask

  // Streams lbytes into the loader; words are packed little-endian by the model.
  task automatic loadBytes(input bit use_last);
    int          n    = lbytes.size();
    int          lane = 0;
    logic [31:0] word = '0;
    bit          last;
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      while (!load_ready && guard < 10) begin
        tick();
        guard++;
      end
      if (!load_ready) begin
        checkOutput("load_ready_timeout", 32'(load_ready), 32'd1);
        return;
      end
      last       = use_last && (i == n - 1);
      load_byte  = lbytes[i];
      load_valid = 1'b1;
      load_last  = last;
      word       = word | (32'(lbytes[i]) << (8 * lane));
      lane++;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      if (lane == IW / 8 || last) begin
        wr_q.push_back('{addr: 32'(mwaddr), data: word});
        ref_mem[mwaddr] = word;
        mwaddr++;
        lane = 0;
        word = '0;
        checkOutput("we_after_word", 32'(imem_we), 32'd1);
      end
    end
    tick();
  endtask

  task automatic applyStimulus(input bit h, input bit b, input logic [PW-1:0] tgt, input bit s);
    halt_req      = h;
    branch_taken  = b;
    branch_target = tgt;
    stall         = s;
    if (h) begin
    end else if (b) begin
      mpc = int'(tgt % MS);
    end else if (!s) begin
      fe_q.push_back('{addr: 32'(mpc), data: ref_mem[mpc]});
      mpc = (mpc + 1) % MS;
    end
    tick();
    halt_req     = 1'b0;
    branch_taken = 1'b0;
    stall        = 1'b0;
  endtask

  task automatic beginLoad();
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    mwaddr     = 0;
  endtask

  // Monitor: a write strobe or a newly registered instruction consumes one expectation.
  always @(negedge clk) begin : monitor
    entry_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (imem_we || instr_valid)
        checkOutput("we_valid_exclusive", 32'(imem_we & instr_valid), 32'd0);
      if (imem_we) begin
        if (wr_q.size() == 0) failNote("unexpected_write", imem_waddr);
        else begin
          e = wr_q.pop_front();
          checkOutput("write_addr", imem_waddr, e.addr);
          checkOutput("write_data", imem_wdata, e.data);
        end
      end
      if (instr_valid && (!prev_valid || pc_out != prev_pc)) begin
        if (fe_q.size() == 0) failNote("unexpected_fetch", pc_out);
        else begin
          e = fe_q.pop_front();
          checkOutput("fetch_pc", pc_out, e.addr);
          checkOutput("fetch_instr", instr_out, e.data);
        end
      end
      prev_valid = instr_valid;
      prev_pc    = pc_out;
    end
  end

  initial begin
    start_load = 0; start_run = 0; load_byte = 0; load_valid = 0; load_last = 0;
    stall = 0; branch_taken = 0; branch_target = 0; halt_req = 0;
    rst_n = 1'b0;
    for (int i = 0; i < MS; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();

    // Two bytes into a word, then reset: nothing may be written.
    beginLoad();
    checkOutput("enter_load", 32'(state), 32'd1);
    load_valid = 1'b1; load_byte = 8'h11; tick();
    load_byte = 8'h22; tick();
    load_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midload_reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Two-word program closed by load_last.
    beginLoad();
    lbytes = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    loadBytes(1'b1);
    checkOutput("run_after_load", 32'(state), 32'd2);
    checkOutput("pc0_after_load", imem_pc, 32'd0);
    mpc = 0;
    applyStimulus(0, 0, '0, 0);
    applyStimulus(0, 0, '0, 0);
    applyStimulus(1, 0, '0, 0);
    checkOutput("halt_state", 32'(state), 32'd3);
    checkOutput("halt_valid", 32'(instr_valid), 32'd0);

    // Partial final word is zero-padded.
    beginLoad();
    lbytes = {8'hAA, 8'hBB, 8'hCC};
    loadBytes(1'b1);
    checkOutput("run_after_partial", 32'(state), 32'd2);
    checkOutput("no_stray_ready", 32'(load_ready), 32'd0);
    mpc = 0;
    repeat (3) applyStimulus(0, 0, '0, 0);
    repeat (3) applyStimulus(0, 0, '0, 1);
    checkOutput("stall_pc_out", pc_out, 32'd2);
    checkOutput("stall_valid", 32'(instr_valid), 32'd1);
    checkOutput("stall_imem_pc", imem_pc, 32'd3);
    repeat (2) applyStimulus(0, 0, '0, 0);

    // Branch beats stall, then wrap from the top address.
    applyStimulus(0, 1, 32'h10, 1);
    checkOutput("branch_bubble", 32'(instr_valid), 32'd0);
    checkOutput("branch_imem_pc", imem_pc, 32'h10);
    applyStimulus(0, 0, '0, 0);
    applyStimulus(0, 1, 32'(MS - 1), 0);
    repeat (2) applyStimulus(0, 0, '0, 0);
    checkOutput("wrap_imem_pc", imem_pc, 32'd1);

    // Halt beats branch and keeps PC.
    applyStimulus(1, 1, 32'd5, 0);
    checkOutput("halt_br_state", 32'(state), 32'd3);
    checkOutput("halt_br_valid", 32'(instr_valid), 32'd0);
    checkOutput("halt_br_pc", imem_pc, 32'(mpc));
    tick();
    checkOutput("halt_hold_pc", imem_pc, 32'(mpc));
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
    mpc = 0;
    checkOutput("restart_state", 32'(state), 32'd2);
    checkOutput("restart_pc", imem_pc, 32'd0);
    repeat (2) applyStimulus(0, 0, '0, 0);

    // Fill the whole memory with random bytes; the top address ends loading.
    applyStimulus(1, 0, '0, 0);
    beginLoad();
    lbytes.delete();
    for (int i = 0; i < MS * (IW / 8); i++) lbytes.push_back(8'($urandom));
    loadBytes(1'b0);
    checkOutput("run_after_full", 32'(state), 32'd2);
    checkOutput("pc0_after_full", imem_pc, 32'd0);
    mpc = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, ($urandom % 10) == 0, PW'($urandom), ($urandom % 5) == 0);
    end

    applyStimulus(0, 0, '0, 1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrun_reset");
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("write_queue_drained", 32'(wr_q.size()), 32'd0);
    checkOutput("fetch_queue_drained", 32'(fe_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
